// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: bundles the controller's connections to pc, mem and alu,
// plus its architectural status outputs.
//   master : the controller (drives pc_op/pc_k, mem_*, alu_*, status)
//   slave  : the surrounding CPU (drives pc_addr, mem_q, alu_c, alu_flags_in)
interface cpu_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  // from pc / mem / alu
  logic [ADDR_W-1:0] pc_addr;
  logic [7:0]        mem_q;
  logic [7:0]        alu_c;
  logic [7:0]        alu_flags_in;
  // to pc
  logic [1:0]        pc_op;
  logic [7:0]        pc_k;
  // to mem
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  // to alu
  logic [3:0]        alu_op;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [7:0]        alu_flags;
  // status
  logic [7:0]        acc;
  logic [7:0]        flags;
  logic              instr_done;
  logic              illegal;
  logic              halted;

  modport master (
    input  pc_addr, mem_q, alu_c, alu_flags_in,
    output pc_op, pc_k, mem_rw, mem_addr, mem_data,
           alu_op, alu_a, alu_b, alu_flags,
           acc, flags, instr_done, illegal, halted
  );

  modport slave (
    output pc_addr, mem_q, alu_c, alu_flags_in,
    input  pc_op, pc_k, mem_rw, mem_addr, mem_data,
           alu_op, alu_a, alu_b, alu_flags,
           acc, flags, instr_done, illegal, halted
  );
endinterface

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle control unit for the 8-bit Von Neumann CPU.
// Sequences the single-port memory for fetch and data access, drives the
// PC op/offset and ALU operands, and holds acc, flags and the instruction
// registers.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - cpu_ctrl_if.master (pc, mem, alu and status signals)
module cpu_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [7:0]  DATA_PAGE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  cpu_ctrl_if.master bus
);

  // pc_op encodings
  localparam logic [1:0] PC_RESET = 2'b00;
  localparam logic [1:0] PC_NOP   = 2'b01;
  localparam logic [1:0] PC_INC   = 2'b10;
  localparam logic [1:0] PC_JUMP  = 2'b11;

  // opcodes (ir_hi[7:4])
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_ST  = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JEQ = 4'h6;
  localparam logic [3:0] OP_JGT = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] ALU_CMP = 4'b0110;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_FETCH2 = 3'd3,
    S_EXEC   = 3'd4,
    S_MEMRD  = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic [7:0] acc_q,   acc_d;
  logic [7:0] flags_q, flags_d;
  logic [7:0] ir_hi_q, ir_hi_d;
  logic [7:0] ir_lo_q, ir_lo_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] data_addr;

  assign opcode    = ir_hi_q[7:4];
  assign data_addr = ADDR_W'({DATA_PAGE, ir_lo_q});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_LD)       state_d = S_MEMRD;
        else if (opcode == OP_HLT) state_d = S_HALT;
        else                       state_d = S_FETCH0;
      end
      S_MEMRD:  state_d = S_FETCH0;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RESET;
    endcase
  end

  // Output decode: PC op, memory access and instruction status per state
  always_comb begin
    bus.pc_op      = PC_NOP;
    bus.mem_rw     = 1'b0;
    bus.mem_addr   = bus.pc_addr;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    unique case (state_q)
      S_RESET: begin
        bus.pc_op    = PC_RESET;
        bus.mem_addr = '0;
      end
      S_FETCH0: bus.mem_addr = bus.pc_addr;
      S_FETCH1: bus.mem_addr = bus.pc_addr + ADDR_W'(1);
      S_FETCH2: ;
      S_EXEC: begin
        unique case (opcode)
          OP_NOP, OP_ALU, OP_LDI: begin
            bus.pc_op      = PC_INC;
            bus.instr_done = 1'b1;
          end
          // LD completes in MEMRD; PC holds until then
          OP_LD: bus.mem_addr = data_addr;
          OP_ST: begin
            bus.pc_op      = PC_INC;
            bus.mem_rw     = 1'b1;
            bus.mem_addr   = data_addr;
            bus.instr_done = 1'b1;
          end
          OP_JMP: begin
            bus.pc_op      = PC_JUMP;
            bus.instr_done = 1'b1;
          end
          // conditional jumps test flags as registered before this EXEC
          OP_JEQ: begin
            bus.pc_op      = flags_q[0] ? PC_JUMP : PC_INC;
            bus.instr_done = 1'b1;
          end
          OP_JGT: begin
            bus.pc_op      = flags_q[1] ? PC_JUMP : PC_INC;
            bus.instr_done = 1'b1;
          end
          // PC freezes at the HLT address
          OP_HLT: bus.instr_done = 1'b1;
          default: begin
            bus.pc_op      = PC_INC;
            bus.illegal    = 1'b1;
            bus.instr_done = 1'b1;
          end
        endcase
      end
      S_MEMRD: begin
        bus.pc_op      = PC_INC;
        bus.instr_done = 1'b1;
      end
      S_HALT: ;
      default: ;
    endcase
  end

  assign bus.halted = (state_q == S_HALT);

  // Datapath next values: instruction capture and architectural updates
  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    ir_hi_d = ir_hi_q;
    ir_lo_d = ir_lo_q;
    unique case (state_q)
      S_FETCH1: ir_hi_d = bus.mem_q;
      S_FETCH2: ir_lo_d = bus.mem_q;
      S_EXEC: begin
        if (opcode == OP_ALU) begin
          // CMP only updates flags
          if (ir_hi_q[3:0] != ALU_CMP) acc_d = bus.alu_c;
          flags_d = bus.alu_flags_in;
        end else if (opcode == OP_LDI) begin
          acc_d = ir_lo_q;
        end
      end
      S_MEMRD: acc_d = bus.mem_q;
      default: ;
    endcase
  end

  // Architectural and instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= 8'h00;
      flags_q <= 8'h00;
      ir_hi_q <= 8'h00;
      ir_lo_q <= 8'h00;
    end else begin
      acc_q   <= acc_d;
      flags_q <= flags_d;
      ir_hi_q <= ir_hi_d;
      ir_lo_q <= ir_lo_d;
    end
  end

  assign bus.pc_k      = ir_lo_q;
  assign bus.mem_data  = acc_q;
  assign bus.alu_op    = ir_hi_q[3:0];
  assign bus.alu_a     = acc_q;
  assign bus.alu_b     = ir_lo_q;
  assign bus.alu_flags = flags_q;
  assign bus.acc       = acc_q;
  assign bus.flags     = flags_q;

endmodule
